// File: rtl/multisim_apb_pkg.sv
// Shared types and default widths for the multisim APB manager bridge.
// The state encoding is visible on the debug port, so it is fixed here.
package multisim_apb_pkg;

  localparam int REQ_WIDTH_DEFAULT  = 69;  // paddr 32 + pwrite 1 + pwdata 32 + pstrb 4
  localparam int RESP_WIDTH_DEFAULT = 33;  // prdata 32 + pslverr 1

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } multisim_apb_state_t;

endpackage

// File: rtl/multisim_apb_fsm.sv
// IDLE/SETUP/ACCESS sequencer for one APB transfer at a time.
// Encoding 3 is unreachable; if it ever shows up, the machine recovers to IDLE.
module multisim_apb_fsm
  import multisim_apb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pready,
  input  logic                timeout,
  output multisim_apb_state_t state
);

  multisim_apb_state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? SETUP : IDLE;
      SETUP:   state_next = ACCESS;
      ACCESS:  state_next = (pready || timeout) ? IDLE : ACCESS;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/multisim_apb_manager_bridge.sv
// Request stream -> APB manager transfer -> single-entry response buffer.
// Handshake: a beat moves on a rising edge where valid && ready are both high.
module multisim_apb_manager_bridge
  import multisim_apb_pkg::*;
#(
  parameter int REQ_WIDTH      = REQ_WIDTH_DEFAULT,
  parameter int RESP_WIDTH     = RESP_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [REQ_WIDTH-1:0]  req_data,
  output logic                  resp_vld,
  input  logic                  resp_rdy,
  output logic [RESP_WIDTH-1:0] resp_data,
  output logic                  resp_timeout,
  output logic [REQ_WIDTH-1:0]  o_apb_req,
  output logic                  o_apb_psel,
  output logic                  o_apb_penable,
  input  logic                  i_apb_pready,
  input  logic [RESP_WIDTH-1:0] i_apb_resp,
  output logic [1:0]            state
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  multisim_apb_state_t cur_state;
  logic                accept;
  logic                access_done;
  logic                timeout_hit;
  logic [CNT_W-1:0]    to_cnt;

  multisim_apb_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .pready  (i_apb_pready),
    .timeout (timeout_hit),
    .state   (cur_state)
  );

  // Ready depends only on registered state, so a drain reopens the input one cycle later.
  assign req_rdy       = (cur_state == IDLE) && !resp_vld;
  assign accept        = req_vld && req_rdy;
  assign o_apb_psel    = (cur_state != IDLE);
  assign o_apb_penable = (cur_state == ACCESS);
  assign state         = cur_state;

  assign access_done = (cur_state == ACCESS) && i_apb_pready;
  // Fires on the ACCESS cycle in which the wait count would reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cur_state == ACCESS) && !i_apb_pready &&
                       (to_cnt == TO_LAST[CNT_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_apb_req    <= '0;
      resp_vld     <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (accept) begin
        o_apb_req <= req_data;
        to_cnt    <= '0;
      end else if ((cur_state == ACCESS) && !i_apb_pready) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end

      if (access_done) begin
        resp_data    <= i_apb_resp;
        resp_timeout <= 1'b0;
        resp_vld     <= 1'b1;
      end else if (timeout_hit) begin
        resp_data    <= '0;
        resp_timeout <= 1'b1;
        resp_vld     <= 1'b1;
      end else if (resp_vld && resp_rdy) begin
        resp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multisim_apb_manager_bridge.sv
// Directed bench for the APB manager bridge: single write, wait states,
// response backpressure, back-to-back stream, timeout and mid-transfer reset.
module tb_multisim_apb_manager_bridge;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_vld;
  logic              req_rdy;
  logic [REQ_W-1:0]  req_data;
  logic              resp_vld;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp_data;
  logic              resp_timeout;
  logic [REQ_W-1:0]  o_apb_req;
  logic              o_apb_psel;
  logic              o_apb_penable;
  logic              i_apb_pready;
  logic [RESP_W-1:0] i_apb_resp;
  logic [1:0]        state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multisim_apb_manager_bridge #(
    .REQ_WIDTH      (REQ_W),
    .RESP_WIDTH     (RESP_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_data      (req_data),
    .resp_vld      (resp_vld),
    .resp_rdy      (resp_rdy),
    .resp_data     (resp_data),
    .resp_timeout  (resp_timeout),
    .o_apb_req     (o_apb_req),
    .o_apb_psel    (o_apb_psel),
    .o_apb_penable (o_apb_penable),
    .i_apb_pready  (i_apb_pready),
    .i_apb_resp    (i_apb_resp),
    .state         (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] paddr, input logic pwrite,
                                               input logic [31:0] pwdata, input logic [3:0] pstrb);
    return {paddr, pwrite, pwdata, pstrb};
  endfunction

  logic [REQ_W-1:0]  w1, r2, r3, t5, q6;
  logic [REQ_W-1:0]  b_req [4];
  logic [RESP_W-1:0] b_rsp [4];

  initial begin
    w1 = mk_req(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    r2 = mk_req(32'h20, 1'b0, 32'h0, 4'h0);
    r3 = mk_req(32'h30, 1'b1, 32'hCAFEF00D, 4'h3);
    t5 = mk_req(32'h50, 1'b0, 32'h0, 4'h0);
    q6 = mk_req(32'h60, 1'b1, 32'h0BADC0DE, 4'hC);
    for (int k = 0; k < 4; k++) begin
      b_req[k] = mk_req(32'h100 + 32'(k * 4), 1'b1, 32'hA5A50000 + 32'(k), 4'hF);
      b_rsp[k] = {32'h5A5A0000 + 32'(k * 16), k[0]};
    end

    rst = 1'b1; req_vld = 1'b0; req_data = '0; resp_rdy = 1'b0;
    i_apb_pready = 1'b0; i_apb_resp = '0;
    tick();
    tick();
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_psel", 128'(o_apb_psel), 128'(0));
    chk("rst_penable", 128'(o_apb_penable), 128'(0));
    chk("rst_apb_req", 128'(o_apb_req), 128'(0));
    chk("rst_resp_vld", 128'(resp_vld), 128'(0));
    chk("rst_resp_data", 128'(resp_data), 128'(0));
    chk("rst_resp_timeout", 128'(resp_timeout), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_req_rdy", 128'(req_rdy), 128'(1));

    // 1: single write, pready high immediately
    req_data = w1; req_vld = 1'b1; i_apb_pready = 1'b1; i_apb_resp = {32'h0, 1'b0};
    tick();
    req_vld = 1'b0; req_data = '1;
    chk("t1_setup_state", 128'(state), 128'(1));
    chk("t1_setup_psel", 128'(o_apb_psel), 128'(1));
    chk("t1_setup_penable", 128'(o_apb_penable), 128'(0));
    chk("t1_setup_req", 128'(o_apb_req), 128'(w1));
    chk("t1_setup_rdy", 128'(req_rdy), 128'(0));
    tick();
    chk("t1_access_psel", 128'(o_apb_psel), 128'(1));
    chk("t1_access_penable", 128'(o_apb_penable), 128'(1));
    chk("t1_access_resp_vld", 128'(resp_vld), 128'(0));
    tick();
    chk("t1_resp_vld", 128'(resp_vld), 128'(1));
    chk("t1_resp_data", 128'(resp_data), 128'({32'h0, 1'b0}));
    chk("t1_resp_timeout", 128'(resp_timeout), 128'(0));
    chk("t1_done_psel", 128'(o_apb_psel), 128'(0));
    chk("t1_held_rdy", 128'(req_rdy), 128'(0));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("t1_drained_vld", 128'(resp_vld), 128'(0));
    chk("t1_drained_rdy", 128'(req_rdy), 128'(1));

    // 2: read with four wait states
    i_apb_pready = 1'b0; req_data = r2; req_vld = 1'b1;
    tick();
    req_vld = 1'b0; req_data = w1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_state", 128'(state), 128'(2));
      chk("t2_wait_req", 128'(o_apb_req), 128'(r2));
      tick();
    end
    chk("t2_last_access", 128'(state), 128'(2));
    chk("t2_last_resp_vld", 128'(resp_vld), 128'(0));
    i_apb_pready = 1'b1; i_apb_resp = {32'h12345678, 1'b1};
    tick();
    i_apb_pready = 1'b0; i_apb_resp = '0;
    chk("t2_resp_vld", 128'(resp_vld), 128'(1));
    chk("t2_resp_data", 128'(resp_data), 128'({32'h12345678, 1'b1}));
    chk("t2_state_idle", 128'(state), 128'(0));

    // 3: response held for 10 cycles while a request waits
    req_data = r3; req_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_vld", 128'(resp_vld), 128'(1));
      chk("t3_hold_data", 128'(resp_data), 128'({32'h12345678, 1'b1}));
      chk("t3_hold_rdy", 128'(req_rdy), 128'(0));
      chk("t3_hold_psel", 128'(o_apb_psel), 128'(0));
      tick();
    end
    resp_rdy = 1'b1;
    chk("t3_drain_cycle_rdy", 128'(req_rdy), 128'(0));
    tick();
    resp_rdy = 1'b0;
    chk("t3_after_drain_vld", 128'(resp_vld), 128'(0));
    chk("t3_after_drain_rdy", 128'(req_rdy), 128'(1));
    chk("t3_after_drain_psel", 128'(o_apb_psel), 128'(0));
    tick();
    req_vld = 1'b0;
    chk("t3_setup_state", 128'(state), 128'(1));
    chk("t3_setup_req", 128'(o_apb_req), 128'(r3));
    i_apb_pready = 1'b1; i_apb_resp = {32'h00000033, 1'b0};
    tick();
    tick();
    chk("t3_resp_data", 128'(resp_data), 128'({32'h00000033, 1'b0}));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;

    // 4: back-to-back stream, always ready on both sides
    resp_rdy = 1'b1; i_apb_pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_data = b_req[k]; req_vld = 1'b1; i_apb_resp = b_rsp[k];
      chk("t4_rdy", 128'(req_rdy), 128'(1));
      tick();
      chk("t4_setup", 128'(state), 128'(1));
      chk("t4_req", 128'(o_apb_req), 128'(b_req[k]));
      tick();
      chk("t4_access", 128'(state), 128'(2));
      tick();
      chk("t4_resp_vld", 128'(resp_vld), 128'(1));
      chk("t4_resp_data", 128'(resp_data), 128'(b_rsp[k]));
      chk("t4_gap_psel", 128'(o_apb_psel), 128'(0));
      tick();
      chk("t4_drained", 128'(resp_vld), 128'(0));
    end
    req_vld = 1'b0; resp_rdy = 1'b0; i_apb_pready = 1'b0;

    // 5: timeout after eight ACCESS cycles
    i_apb_resp = {32'hFFFFFFFF, 1'b1};
    req_data = t5; req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("t5_access", 128'(state), 128'(2));
      chk("t5_no_resp", 128'(resp_vld), 128'(0));
      tick();
    end
    chk("t5_access8", 128'(state), 128'(2));
    tick();
    chk("t5_resp_vld", 128'(resp_vld), 128'(1));
    chk("t5_resp_timeout", 128'(resp_timeout), 128'(1));
    chk("t5_resp_data", 128'(resp_data), 128'(0));
    chk("t5_state_idle", 128'(state), 128'(0));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;

    // 6: reset while in ACCESS, then a normal transfer
    req_data = q6; req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    tick();
    chk("t6_in_access", 128'(state), 128'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_state", 128'(state), 128'(0));
    chk("t6_rst_psel", 128'(o_apb_psel), 128'(0));
    chk("t6_rst_penable", 128'(o_apb_penable), 128'(0));
    chk("t6_rst_resp_vld", 128'(resp_vld), 128'(0));
    chk("t6_rst_req", 128'(o_apb_req), 128'(0));
    chk("t6_rst_timeout", 128'(resp_timeout), 128'(0));
    tick();
    tick();
    chk("t6_abandoned", 128'(resp_vld), 128'(0));
    i_apb_pready = 1'b1; i_apb_resp = {32'h00C0FFEE, 1'b0};
    req_data = q6; req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    chk("t6_setup_req", 128'(o_apb_req), 128'(q6));
    tick();
    tick();
    chk("t6_resp_vld", 128'(resp_vld), 128'(1));
    chk("t6_resp_data", 128'(resp_data), 128'({32'h00C0FFEE, 1'b0}));
    chk("t6_resp_timeout", 128'(resp_timeout), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
